// File: rtl/reg_file_sb.sv
// reg_file_sb: parametrised register file with write-back scoreboard.
// Two combinational read ports (optional same-cycle write bypass), one
// write-back port, per-register busy flags with issue-stall generation,
// a one-cycle-latency debug read port and a fixed observation output.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data  write-back; stores data and clears busy
//   rs1/rs2 -> rd_a/rd_b   combinational reads
//   hazard_a/hazard_b      source operand still in flight
//   iss_en/iss_rd          issue request reserving a destination
//   iss_stall              issue refused this cycle
//   busy_vec               registered busy flags, one per register
//   dbg_addr -> dbg_data   registered debug read of the stored array
//   obs_out                stored contents of register OBS_REG
module reg_file_sb #(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 3,
  parameter int unsigned ZERO_R0 = 0,
  parameter int unsigned BYPASS  = 1,
  parameter int unsigned OBS_REG = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic [ADDR_W-1:0]       rs1,
  input  logic [ADDR_W-1:0]       rs2,
  output logic [DATA_W-1:0]       rd_a,
  output logic [DATA_W-1:0]       rd_b,
  input  logic                    iss_en,
  input  logic [ADDR_W-1:0]       iss_rd,
  output logic                    iss_stall,
  output logic                    hazard_a,
  output logic                    hazard_b,
  output logic [(1<<ADDR_W)-1:0]  busy_vec,
  input  logic [ADDR_W-1:0]       dbg_addr,
  output logic [DATA_W-1:0]       dbg_data,
  output logic [DATA_W-1:0]       obs_out
);

  localparam int unsigned       DEPTH   = 1 << ADDR_W;
  localparam bit                ZERO_EN = (ZERO_R0 != 0);
  localparam bit                BYP_EN  = (BYPASS != 0);
  localparam logic [ADDR_W-1:0] OBS_IDX = ADDR_W'(OBS_REG);

  logic [DATA_W-1:0] bank_q [DEPTH];
  logic [DATA_W-1:0] bank_d [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] dbg_q, dbg_d;

  logic zero_a, zero_b, zero_w, zero_i;
  logic fwd_a, fwd_b;
  logic hz_a, hz_b, hz_d;
  logic iss_ok;

  // Read ports, bypass and hazard detection.
  always_comb begin
    zero_a = ZERO_EN && (rs1 == '0);
    zero_b = ZERO_EN && (rs2 == '0);
    zero_w = ZERO_EN && (wr_addr == '0);
    zero_i = ZERO_EN && (iss_rd == '0);

    fwd_a = BYP_EN && wr_en && (wr_addr == rs1) && !zero_a;
    fwd_b = BYP_EN && wr_en && (wr_addr == rs2) && !zero_b;

    rd_a = zero_a ? '0 : (fwd_a ? wr_data : bank_q[rs1]);
    rd_b = zero_b ? '0 : (fwd_b ? wr_data : bank_q[rs2]);

    hz_a = busy_q[rs1] && !fwd_a && !zero_a;
    hz_b = busy_q[rs2] && !fwd_b && !zero_b;
    // WAW guard: a destination still in flight may only be re-reserved
    // in the cycle its pending result writes back.
    hz_d = busy_q[iss_rd] && !(wr_en && (wr_addr == iss_rd)) && !zero_i;

    iss_ok    = iss_en && !hz_a && !hz_b && !hz_d;
    iss_stall = iss_en && !iss_ok;
    hazard_a  = hz_a;
    hazard_b  = hz_b;
  end

  // Next-state for array, busy flags and debug register.
  always_comb begin
    bank_d = bank_q;
    busy_d = busy_q;
    dbg_d  = bank_q[dbg_addr];
    if (wr_en && !zero_w) begin
      bank_d[wr_addr] = wr_data;
      busy_d[wr_addr] = 1'b0;
    end
    // Applied after the clear so a same-register reservation wins.
    if (iss_ok && !zero_i) begin
      busy_d[iss_rd] = 1'b1;
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        bank_q[i] <= '0;
      end
      busy_q <= '0;
      dbg_q  <= '0;
    end else begin
      bank_q <= bank_d;
      busy_q <= busy_d;
      dbg_q  <= dbg_d;
    end
  end

  assign busy_vec = busy_q;
  assign dbg_data = dbg_q;
  assign obs_out  = bank_q[OBS_IDX];

endmodule
